// File: rtl/img_pkg.sv
// Shared constants, state encoding and index helper for the raster image path.
// Used by the image assembler and reusable by the scanner side.
package img_pkg;

  localparam int unsigned COLS = 8;                  // pixels per row
  localparam int unsigned ROWS = 8;                  // rows per frame
  localparam int unsigned XW   = 3;                  // clog2(COLS)
  localparam int unsigned YW   = 3;                  // clog2(ROWS)
  localparam int unsigned NPIX = COLS * ROWS;        // pixels per frame
  localparam int unsigned IW   = $clog2(NPIX);       // flat pixel index width
  localparam int unsigned CW   = $clog2(NPIX + 1);   // set-pixel count width

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StHold
  } state_e;

  // Flat raster index of pixel (x, y): row-major, row 0 first.
  function automatic logic [IW-1:0] pix_index(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return IW'(int'(y) * int'(COLS) + int'(x));
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position counter (cx, cy): cx advances first and wraps into cy.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr_i     - return to (0, 0)
//   load1_i   - jump to (1, 0), i.e. just after pixel 0 was consumed
//   adv_i     - step to the next raster position
//   cx_o/cy_o - current column / row
//   last_o    - current position is the final pixel of the frame
module raster_counter
  import img_pkg::*;
#(
  parameter int unsigned Cols = COLS,
  parameter int unsigned Rows = ROWS,
  parameter int unsigned Xw   = XW,
  parameter int unsigned Yw   = YW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          load1_i,
  input  logic          adv_i,
  output logic [Xw-1:0] cx_o,
  output logic [Yw-1:0] cy_o,
  output logic          last_o
);

  logic [Xw-1:0] cx_q, cx_d;
  logic [Yw-1:0] cy_q, cy_d;
  logic          cx_end, cy_end;

  assign cx_end = (cx_q == Xw'(Cols - 1));
  assign cy_end = (cy_q == Yw'(Rows - 1));

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clr_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (load1_i) begin
      cx_d = Xw'(1);
      cy_d = '0;
    end else if (adv_i) begin
      if (cx_end) begin
        cx_d = '0;
        cy_d = cy_end ? '0 : cy_q + Yw'(1);
      end else begin
        cx_d = cx_q + Xw'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx_o   = cx_q;
  assign cy_o   = cy_q;
  assign last_o = cx_end && cy_end;

endmodule

// File: rtl/image_assembler.sv
// Rebuilds a COLS x ROWS binary image from a raster pixel stream and presents
// the finished frame with a valid/ready handshake.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid_i        - stream beat valid
//   in_ready_o        - beat can be accepted (low in HOLD and during reset)
//   in_sof_i          - beat is pixel 0 of a frame
//   in_pix_i          - pixel value
//   in_x_i, in_y_i    - claimed coordinates, only meaningful for set pixels
//   img_o             - assembled image, img_o[y*COLS+x], img_o[0] = row 0/col 0
//   img_valid_o       - frame complete
//   out_ready_i       - downstream takes the frame
//   pix_count_o       - number of set pixels in the frame
//   err_o             - a set pixel arrived with coordinates off the raster position
module image_assembler
  import img_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            in_sof_i,
  input  logic            in_pix_i,
  input  logic [XW-1:0]   in_x_i,
  input  logic [YW-1:0]   in_y_i,
  output logic [0:NPIX-1] img_o,
  output logic            img_valid_o,
  input  logic            out_ready_i,
  output logic [CW-1:0]   pix_count_o,
  output logic            err_o
);

  state_e          state_q, state_d;
  logic [0:NPIX-1] img_q, img_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            accept;
  logic            clr, load1, adv;
  logic [XW-1:0]   cx;
  logic [YW-1:0]   cy;
  logic            last;

  raster_counter u_raster_counter (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .load1_i (load1),
    .adv_i   (adv),
    .cx_o    (cx),
    .cy_o    (cy),
    .last_o  (last)
  );

  // Ready is gated by rst so nothing looks acceptable while reset is held.
  assign in_ready_o = (state_q != StHold) && !rst;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    clr     = 1'b0;
    load1   = 1'b0;
    adv     = 1'b0;

    unique case (state_q)
      StIdle, StFill: begin
        if (accept && in_sof_i) begin
          // Start (or restart) a frame: previous contents are discarded.
          img_d    = '0;
          img_d[0] = in_pix_i;
          cnt_d    = CW'(in_pix_i);
          err_d    = in_pix_i && ((in_x_i != '0) || (in_y_i != '0));
          load1    = 1'b1;
          state_d  = StFill;
        end else if (accept && (state_q == StFill)) begin
          img_d[pix_index(cx, cy)] = in_pix_i;
          cnt_d = cnt_q + CW'(in_pix_i);
          // Zero pixels carry stale coordinates, so only set pixels are checked.
          if (in_pix_i && ((in_x_i != cx) || (in_y_i != cy))) begin
            err_d = 1'b1;
          end
          if (last) begin
            clr     = 1'b1;
            state_d = StHold;
          end else begin
            adv = 1'b1;
          end
        end
      end
      StHold: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      img_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      img_q   <= img_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign img_o       = img_q;
  assign img_valid_o = (state_q == StHold);
  assign pix_count_o = cnt_q;
  assign err_o       = err_q;

endmodule
